// File: rtl/multiplier_accumulate_stage.sv
// rtl/multiplier_accumulate_stage.sv - Booth multiplier accumulate stage: shifts each partial product to its digit weight and sums into Hi/Lo.
module multiplier_accumulate_stage #(
    parameter int DIGITS = 11,
    parameter int SHIFT  = 3
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        En,
    input  logic        Start,
    input  logic [63:0] BoothOut,
    output logic [3:0]  Step,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] acc_q, acc_d;
    logic [3:0]  step_q, step_d;
    logic        done_q, done_d;
    logic [63:0] prod_q, prod_d;
    logic [63:0] shifted;
    logic [63:0] sum;
    logic        last_digit;

    // Digit weights are a small fixed set, so a constant-shift mux replaces a barrel shifter.
    always_comb begin
        shifted = 64'd0;
        case (step_q)
            4'd0:    shifted = BoothOut;
            4'd1:    shifted = BoothOut << (SHIFT * 1);
            4'd2:    shifted = BoothOut << (SHIFT * 2);
            4'd3:    shifted = BoothOut << (SHIFT * 3);
            4'd4:    shifted = BoothOut << (SHIFT * 4);
            4'd5:    shifted = BoothOut << (SHIFT * 5);
            4'd6:    shifted = BoothOut << (SHIFT * 6);
            4'd7:    shifted = BoothOut << (SHIFT * 7);
            4'd8:    shifted = BoothOut << (SHIFT * 8);
            4'd9:    shifted = BoothOut << (SHIFT * 9);
            4'd10:   shifted = BoothOut << (SHIFT * 10);
            default: shifted = 64'd0;
        endcase
    end

    assign sum        = acc_q + shifted;
    assign last_digit = (step_q == 4'(DIGITS - 1));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        step_d  = step_q;
        done_d  = done_q;
        prod_d  = prod_q;
        // With En low every register holds, which also stretches a Done pulse.
        if (En) begin
            done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        acc_d   = 64'd0;
                        step_d  = 4'd0;
                        state_d = ACCUM;
                    end
                end
                ACCUM: begin
                    acc_d = sum;
                    if (last_digit) begin
                        step_d  = 4'd0;
                        prod_d  = sum;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        step_d = step_q + 4'd1;
                    end
                end
                DONE: begin
                    if (Start) begin
                        acc_d   = 64'd0;
                        step_d  = 4'd0;
                        state_d = ACCUM;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    step_d  = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            acc_q   <= 64'd0;
            step_q  <= 4'd0;
            done_q  <= 1'b0;
            prod_q  <= 64'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            done_q  <= done_d;
            prod_q  <= prod_d;
        end
    end

    assign Step = step_q;
    assign Busy = (state_q == ACCUM);
    assign Done = done_q;
    assign Hi   = prod_q[63:32];
    assign Lo   = prod_q[31:0];

endmodule

// File: tb/tb_multiplier_accumulate_stage.sv
// tb/tb_multiplier_accumulate_stage.sv - self-checking bench for multiplier_accumulate_stage with a radix-8 Booth upstream model.
module tb_multiplier_accumulate_stage;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        En;
    logic        Start;
    logic [63:0] booth_out;
    logic [3:0]  Step;
    logic        Busy;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;

    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        op_s = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    multiplier_accumulate_stage #(.DIGITS(11), .SHIFT(3)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .En       (En),
        .Start    (Start),
        .BoothOut (booth_out),
        .Step     (Step),
        .Busy     (Busy),
        .Done     (Done),
        .Hi       (Hi),
        .Lo       (Lo)
    );

    always #5 Clk = ~Clk;

    // Upstream model: radix-8 Booth digit for group i times the extended multiplicand.
    function automatic logic [63:0] booth_pp(input logic [31:0] a, input logic [31:0] b,
                                             input logic s, input logic [3:0] i);
        logic [34:0] bx;
        int          d;
        int          k;
        longint      av;
        if (i > 4'd10) return 64'd0;
        bx = {1'b0, s & b[31], b, 1'b0};
        k  = 3 * int'(i);
        d  = -4 * int'(bx[k+3]) + 2 * int'(bx[k+2]) + int'(bx[k+1]) + int'(bx[k]);
        av = s ? longint'($signed(a)) : longint'({32'd0, a});
        return 64'(av * longint'(d));
    endfunction

    assign booth_out = booth_pp(op_a, op_b, op_s, Step);

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (s) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int stall_at, output logic [63:0] res, output int lat);
        bit stalled;
        op_a  = a;
        op_b  = b;
        op_s  = s;
        Start = 1'b1;
        tick();
        Start   = 1'b0;
        lat     = 0;
        stalled = 0;
        while (Done !== 1'b1 && lat < 40) begin
            if (stall_at >= 0 && !stalled && Step == 4'(stall_at)) begin
                stalled = 1;
                En      = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    lat++;
                    check("stall_step", 64'(Step), 64'(stall_at));
                end
                En = 1'b1;
            end else begin
                tick();
                lat++;
            end
        end
        res = {Hi, Lo};
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        int          stall;
        logic [63:0] exp;
    } vec_t;

    vec_t        vecs[10];
    logic [63:0] res;
    logic [63:0] first_res;
    int          lat;
    int          guard;
    int          done_seen;

    initial begin
        Reset = 1'b0;
        En    = 1'b1;
        Start = 1'b0;

        vecs[0] = '{32'd3,          32'd5,          1'b0, -1, 64'h0000_0000_0000_000F};
        vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, -1, 64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, -1, 64'h0000_0000_0000_0001};
        vecs[3] = '{32'h8000_0000,  32'h8000_0000,  1'b1, -1, 64'h4000_0000_0000_0000};
        vecs[4] = '{32'h8000_0000,  32'h0000_0001,  1'b1, -1, 64'hFFFF_FFFF_8000_0000};
        vecs[5] = '{32'd7,          32'd9,          1'b0,  4, 64'd63};
        for (int i = 6; i < 10; i++) begin
            vecs[i].a     = $urandom;
            vecs[i].b     = $urandom;
            vecs[i].s     = 1'($urandom_range(0, 1));
            vecs[i].stall = -1;
            vecs[i].exp   = ref_mul(vecs[i].a, vecs[i].b, vecs[i].s);
        end

        #12;
        check("reset_step", 64'(Step), 64'd0);
        check("reset_busy", 64'(Busy), 64'd0);
        check("reset_done", 64'(Done), 64'd0);
        check("reset_hilo", {Hi, Lo}, 64'd0);
        @(posedge Clk);
        #1 Reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].stall, res, lat);
            check($sformatf("latency[%0d]", i), 64'(lat), (vecs[i].stall >= 0) ? 64'd14 : 64'd11);
            check($sformatf("product[%0d]", i), res, vecs[i].exp);
            check($sformatf("busy_in_done[%0d]", i), 64'(Busy), 64'd0);
            tick();
            check($sformatf("done_width[%0d]", i), 64'(Done), 64'd0);
            check($sformatf("idle_step[%0d]", i), 64'(Step), 64'd0);
            check($sformatf("hilo_hold[%0d]", i), {Hi, Lo}, vecs[i].exp);
        end

        // Start raised during ACCUM must not disturb the operation in flight.
        op_a  = 32'd1234;
        op_b  = 32'd5678;
        op_s  = 1'b0;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        lat   = 0;
        for (int k = 0; k < 3; k++) begin tick(); lat++; end
        check("accum_busy", 64'(Busy), 64'd1);
        Start = 1'b1;
        tick();
        lat++;
        Start = 1'b0;
        while (Done !== 1'b1 && lat < 40) begin tick(); lat++; end
        check("ignored_start_latency", 64'(lat), 64'd11);
        check("ignored_start_product", {Hi, Lo}, 64'd7006652);
        tick();

        // Reset in the middle of an operation aborts it with no Done.
        op_a  = 32'hDEAD_BEEF;
        op_b  = 32'h1234_5678;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        guard = 0;
        while (Step != 4'd6 && guard < 20) begin tick(); guard++; end
        check("reach_step6", 64'(Step), 64'd6);
        Reset = 1'b0;
        #2;
        check("async_rst_step", 64'(Step), 64'd0);
        check("async_rst_busy", 64'(Busy), 64'd0);
        check("async_rst_done", 64'(Done), 64'd0);
        check("async_rst_hilo", {Hi, Lo}, 64'd0);
        tick();
        tick();
        Reset     = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (Done === 1'b1) done_seen++;
        end
        check("no_done_after_reset", 64'(done_seen), 64'd0);
        run_op(32'd3, 32'd5, 1'b0, -1, res, lat);
        check("post_reset_latency", 64'(lat), 64'd11);
        check("post_reset_product", res, 64'd15);
        tick();

        // Back-to-back: Start held high through DONE.
        op_a  = 32'd100000;
        op_b  = 32'd300000;
        op_s  = 1'b0;
        Start = 1'b1;
        tick();
        lat = 0;
        while (Done !== 1'b1 && lat < 40) begin tick(); lat++; end
        check("b2b_first_latency", 64'(lat), 64'd11);
        first_res = ref_mul(32'd100000, 32'd300000, 1'b0);
        check("b2b_first_product", {Hi, Lo}, first_res);
        op_a = 32'hFFFF_FFF9;
        op_b = 32'd13;
        op_s = 1'b1;
        tick();
        lat = 1;
        check("b2b_done_width", 64'(Done), 64'd0);
        check("b2b_restart_busy", 64'(Busy), 64'd1);
        for (int k = 0; k < 5; k++) begin tick(); lat++; end
        check("b2b_hilo_held", {Hi, Lo}, first_res);
        while (Done !== 1'b1 && lat < 40) begin tick(); lat++; end
        check("b2b_interval", 64'(lat), 64'd12);
        check("b2b_second_product", {Hi, Lo}, ref_mul(32'hFFFF_FFF9, 32'd13, 1'b1));
        Start = 1'b0;
        tick();
        check("b2b_second_done_width", 64'(Done), 64'd0);
        check("b2b_final_busy", 64'(Busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
